// File: rtl/echo_delay_line_if.sv
// Sample/config handshake bundle between the codec source, the echo stage and the sink mixer.
// Signal names keep the block's i_/o_ port names so the stage reads the same from either side.
`timescale 1ns/1ps
interface echo_delay_line_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16,
    parameter int GAIN_W = 8
);
    logic                     i_en;
    logic                     i_mode;
    logic [ADDR_W-1:0]        i_delay;
    logic [GAIN_W-1:0]        i_gain;
    logic signed [DATA_W-1:0] i_data;
    logic                     i_dv;
    logic                     o_ready;
    logic signed [DATA_W-1:0] o_data;
    logic                     o_dv;

    modport master (
        output i_en, i_mode, i_delay, i_gain, i_data, i_dv,
        input  o_ready, o_data, o_dv
    );

    modport slave (
        input  i_en, i_mode, i_delay, i_gain, i_data, i_dv,
        output o_ready, o_data, o_dv
    );
endinterface

// File: rtl/echo_delay_line.sv
// Mono echo/delay stage: circular history RAM, Q0.GAIN_W echo gain, feed-forward or feedback
// mixing with saturation. One sample is processed every five clocks.
`timescale 1ns/1ps
module echo_delay_line #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 16,
    parameter int MAX_DEPTH = 24000,
    parameter int GAIN_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    echo_delay_line_if.slave   bus
);

    // state  | meaning
    // IDLE   | o_ready high, waiting for i_dv
    // RD     | RAM addressed with the delayed read pointer
    // WAIT   | RAM read data registered as d
    // MIX    | echo scaled, added and saturated; result loaded into o_data
    // WR     | o_dv strobe, history written, pointers advanced
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MIX,
        S_WR
    } state_t;

    localparam int IDX_W = $clog2(MAX_DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(MAX_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MAX_DEPTH - 1);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state_q, state_d;

    logic ready_q, ready_d;
    logic dv_q, dv_d;
    logic en_q, en_d;
    logic mode_q, mode_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] d_q, d_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [ADDR_W:0]   dly_q, dly_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [ADDR_W:0]   dly_clamp;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata_q;
    logic [DATA_W-1:0] mem [MAX_DEPTH];

    logic signed [DATA_W-1:0]        d_eff;
    logic signed [DATA_W+GAIN_W:0]   prod;
    logic signed [DATA_W:0]          e_ext;
    logic signed [DATA_W:0]          sum;
    logic signed [DATA_W-1:0]        y;
    logic                            unused_bits;

    assign bus.o_ready = ready_q;
    assign bus.o_data  = data_q;
    assign bus.o_dv    = dv_q;

    always_comb begin
        dly_clamp = {1'b0, bus.i_delay};
        if (bus.i_delay == '0) begin
            dly_clamp = (ADDR_W+1)'(1);
        end else if ({1'b0, bus.i_delay} > DEPTH_L) begin
            dly_clamp = DEPTH_L;
        end
    end

    // Modular subtract, then fold back into [0, MAX_DEPTH) when the delay reaches past slot 0.
    always_comb begin
        rd_ptr = wr_ptr_q - dly_q[ADDR_W-1:0];
        if ({1'b0, wr_ptr_q} < dly_q) begin
            rd_ptr = rd_ptr + DEPTH_L[ADDR_W-1:0];
        end
    end

    always_comb begin
        d_eff = (dly_q > fill_q) ? '0 : d_q;
        prod  = $signed({{(GAIN_W+1){d_eff[DATA_W-1]}}, d_eff})
              * $signed({{DATA_W{1'b0}}, gain_q});
        // Dropping the fraction bits of a two's-complement product is a floor.
        e_ext = prod[DATA_W+GAIN_W:GAIN_W];
        sum   = {x_q[DATA_W-1], x_q} + e_ext;
        y     = sum[DATA_W-1:0];
        if (!en_q) begin
            y = x_q;
        end else if (sum[DATA_W] != sum[DATA_W-1]) begin
            y = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

    assign unused_bits = ^{prod[GAIN_W-1:0], ram_addr};

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        dv_d      = dv_q;
        en_d      = en_q;
        mode_d    = mode_q;
        data_d    = data_q;
        x_d       = x_q;
        d_d       = d_q;
        gain_d    = gain_q;
        dly_d     = dly_q;
        fill_d    = fill_q;
        wr_ptr_d  = wr_ptr_q;
        ram_we    = 1'b0;
        ram_addr  = wr_ptr_q;
        ram_wdata = (mode_q && en_q) ? data_q : x_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_dv && ready_q) begin
                    x_d     = bus.i_data;
                    en_d    = bus.i_en;
                    mode_d  = bus.i_mode;
                    gain_d  = bus.i_gain;
                    dly_d   = dly_clamp;
                    ready_d = 1'b0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                ram_addr = rd_ptr;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                d_d     = $signed(ram_rdata_q);
                state_d = S_MIX;
            end
            S_MIX: begin
                data_d  = y;
                dv_d    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                ram_we   = 1'b1;
                dv_d     = 1'b0;
                ready_d  = 1'b1;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                if (fill_q != DEPTH_L) begin
                    fill_d = fill_q + 1'b1;
                end
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            dv_q     <= 1'b0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            x_q      <= '0;
            d_q      <= '0;
            gain_q   <= '0;
            dly_q    <= (ADDR_W+1)'(1);
            fill_q   <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            dv_q     <= dv_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            x_q      <= x_d;
            d_q      <= d_d;
            gain_q   <= gain_d;
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // History RAM is deliberately not reset; fill_q masks stale contents instead.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[ram_addr[IDX_W-1:0]] <= ram_wdata;
        end
        ram_rdata_q <= mem[ram_addr[IDX_W-1:0]];
    end

endmodule
